// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and sizing helpers for the UART receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Runtime parity selection; RSVD behaves as NONE.
    typedef enum logic [1:0] {
        NONE = 2'b00,
        EVEN = 2'b01,
        ODD  = 2'b10,
        RSVD = 2'b11
    } parity_mode_e;

    // Receiver states; the core keeps them as plain 3-bit constants.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        BRKWAIT = 3'd5
    } rx_state_e;

    localparam int c_STATE_W = 3;

    // Centre sample index within one bit period.
    function automatic int mid_of(input int os);
        return os / 2;
    endfunction

    // Width of the per-bit oversample counter (0..OVERSAMPLE-1).
    function automatic int samp_cnt_w(input int os);
        return $clog2(os);
    endfunction

    // Width of the data-bit counter.
    function automatic int bit_cnt_w(input int db);
        return $clog2(db + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Oversample tick prescaler. Counts 0..baud_div and pulses
//                tick on the terminal count; clear holds the count at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    // Terminal count; a divisor of zero ticks every clock.
    assign tick = (r_cnt == baud_div);

    // Free-running prescale counter, restarted by clear or terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_rx_core
//  Description : Oversampled UART receiver with start-bit qualification,
//                3-sample majority vote, runtime baud divisor and parity mode,
//                framing / parity error and line-break reporting.
//                Optional macro UART_RX_PARITY_EN builds the parity stage;
//                without it every frame is received as no-parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 rx_busy
);

    localparam int MID   = mid_of(OVERSAMPLE);
    localparam int CNT_W = samp_cnt_w(OVERSAMPLE);
    localparam int BIT_W = bit_cnt_w(DATA_BITS);

    localparam logic [CNT_W-1:0] c_CNT_MID_M1 = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] c_CNT_MID    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] c_CNT_MID_P1 = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] c_BIT_LAST   = BIT_W'(DATA_BITS - 1);

    localparam logic [c_STATE_W-1:0] c_ST_IDLE    = IDLE;
    localparam logic [c_STATE_W-1:0] c_ST_START   = START;
    localparam logic [c_STATE_W-1:0] c_ST_DATA    = DATA;
`ifdef UART_RX_PARITY_EN
    localparam logic [c_STATE_W-1:0] c_ST_PARITY  = PARITY;
`endif
    localparam logic [c_STATE_W-1:0] c_ST_STOP    = STOP;
    localparam logic [c_STATE_W-1:0] c_ST_BRKWAIT = BRKWAIT;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rx_prev;
    logic [c_STATE_W-1:0] r_state;
    logic [CNT_W-1:0]     r_samp_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_s0;
    logic                 r_s1;
    logic [DIV_W-1:0]     r_baud_div_q;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_data_ready;
    logic                 r_frame_err;
    logic                 r_break_det;
    logic                 r_rx_busy;

    logic                 w_tick;
    logic                 w_fall;
    logic                 w_vote;
    logic                 w_at_vote;
    logic                 w_at_end;
    logic                 w_presc_clr;
    logic                 w_par_term;
    logic                 w_brk;

`ifdef UART_RX_PARITY_EN
    parity_mode_e         r_par_mode_q;
    logic                 r_par_bad;
    logic                 r_par_zero;
    logic                 r_parity_err;
    logic                 w_par_active;
    logic                 w_par_exp;
`else
    logic                 w_unused_parity_mode;
`endif

    // ------------------------------------------------------------------
    // Input synchroniser and edge register; all idle high so reset does
    // not fabricate a start edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_fall = r_rx_prev & ~r_sync2;

    // ------------------------------------------------------------------
    // Prescaler: held cleared whenever no frame is in progress, so the
    // first tick of a frame lands a fixed distance after the start edge.
    // ------------------------------------------------------------------
    assign w_presc_clr = (r_state == c_ST_IDLE) || (r_state == c_ST_BRKWAIT);

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_presc_clr),
        .baud_div (r_baud_div_q),
        .tick     (w_tick)
    );

    // Runtime configuration is frozen at the start edge for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_div_q <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_mode_q <= NONE;
`endif
        end else if ((r_state == c_ST_IDLE) && w_fall) begin
            r_baud_div_q <= baud_div;
`ifdef UART_RX_PARITY_EN
            r_par_mode_q <= parity_mode_e'(parity_mode);
`endif
        end
    end

    // Oversample position within the current bit; wraps at bit end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp_cnt <= '0;
        end else if (w_presc_clr) begin
            r_samp_cnt <= '0;
        end else if (w_tick) begin
            r_samp_cnt <= (r_samp_cnt == c_CNT_LAST) ? '0 : r_samp_cnt + 1'b1;
        end
    end

    // Capture the two early samples; the third is taken live at MID+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else if (w_tick) begin
            if (r_samp_cnt == c_CNT_MID_M1) r_s0 <= r_sync2;
            if (r_samp_cnt == c_CNT_MID)    r_s1 <= r_sync2;
        end
    end

    assign w_vote    = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
    assign w_at_vote = w_tick && (r_samp_cnt == c_CNT_MID_P1);
    assign w_at_end  = w_tick && (r_samp_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // Parity evaluation and the parity contribution to break detection.
    // ------------------------------------------------------------------
`ifdef UART_RX_PARITY_EN
    assign w_par_active = (r_par_mode_q == EVEN) || (r_par_mode_q == ODD);
    assign w_par_exp    = (^r_shift) ^ (r_par_mode_q == ODD);
    assign w_par_term   = ~w_par_active | r_par_zero;
    assign parity_err   = r_parity_err;
`else
    assign w_unused_parity_mode = ^parity_mode;
    assign w_par_term           = 1'b1;
    assign parity_err           = 1'b0;
`endif

    // Break: every data bit low, parity low when present, stop low.
    assign w_brk = ~w_vote & (r_shift == '0) & w_par_term;

    // ------------------------------------------------------------------
    // Receive state machine and registered result outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_data_ready <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break_det  <= 1'b0;
            r_rx_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_par_zero   <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_data_ready <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_fall) begin
                        r_state     <= c_ST_START;
                        r_bit_cnt   <= '0;
                        r_rx_busy   <= 1'b1;
                        r_frame_err <= 1'b0;
                        r_break_det <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= 1'b0;
                        r_par_bad    <= 1'b0;
                        r_par_zero   <= 1'b0;
`endif
                    end
                end
                c_ST_START: begin
                    if (w_at_vote && w_vote) begin
                        // Start bit not confirmed at mid-bit: treat as noise.
                        r_state   <= c_ST_IDLE;
                        r_rx_busy <= 1'b0;
                    end else if (w_at_end) begin
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_at_vote) begin
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    end
                    if (w_at_end) begin
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= w_par_active ? c_ST_PARITY : c_ST_STOP;
`else
                            r_state   <= c_ST_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_ST_PARITY: begin
                    if (w_at_vote) begin
                        r_par_bad  <= (w_vote != w_par_exp);
                        r_par_zero <= ~w_vote;
                    end
                    if (w_at_end) begin
                        r_state <= c_ST_STOP;
                    end
                end
`endif
                c_ST_STOP: begin
                    // Finish at mid-stop so the next start edge has margin.
                    if (w_at_vote) begin
                        r_data_ready <= 1'b1;
                        r_rx_busy    <= 1'b0;
                        r_rx_data    <= r_shift;
                        r_frame_err  <= ~w_vote;
                        r_break_det  <= w_brk;
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= r_par_bad;
`endif
                        r_state      <= w_brk ? c_ST_BRKWAIT : c_ST_IDLE;
                    end
                end
                c_ST_BRKWAIT: begin
                    // A line held low must rise before a new frame can start.
                    if (r_sync2) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_rx_busy <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data    = r_rx_data;
    assign data_ready = r_data_ready;
    assign frame_err  = r_frame_err;
    assign break_det  = r_break_det;
    assign rx_busy    = r_rx_busy;

endmodule
`default_nettype wire
